// File: rtl/reg_file.sv
// 32-entry register file with write-back source/destination selection,
// debug read port and saturating write counter. Define RF_BYPASS_EN for write-through reads.
module reg_file #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic             RegDst,
    input  logic             RegWre,
    input  logic             DBDataSrc,
    input  logic [WIDTH-1:0] result,
    input  logic [WIDTH-1:0] DataOut,
    input  logic [4:0]       DbgAddr,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic [WIDTH-1:0] DbgData,
    output logic [WIDTH-1:0] WriteData,
    output logic [CNT_W-1:0] WrCount
);

    // Register 0 has no storage; its reads are forced to zero below.
    logic [WIDTH-1:0] regs_q [1:31];
    logic [WIDTH-1:0] regs_d [1:31];
    logic [CNT_W-1:0] wr_count_q;
    logic [CNT_W-1:0] wr_count_d;
    logic [4:0]       write_reg;
    logic             wr_en;

    always_comb begin
        write_reg = RegDst ? rd : rt;
        WriteData = DBDataSrc ? DataOut : result;
        wr_en     = RegWre && (write_reg != 5'd0);

        regs_d = regs_q;
        if (wr_en) begin
            regs_d[write_reg] = WriteData;
        end

        wr_count_d = wr_count_q;
        if (wr_en && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            regs_q     <= '{default: '0};
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        ReadData1 = (rs == 5'd0)      ? '0 : regs_q[rs];
        ReadData2 = (rt == 5'd0)      ? '0 : regs_q[rt];
        DbgData   = (DbgAddr == 5'd0) ? '0 : regs_q[DbgAddr];
`ifdef RF_BYPASS_EN
        // wr_en already excludes register 0, so zero reads stay zero.
        if (wr_en && (rs == write_reg)) begin
            ReadData1 = WriteData;
        end
        if (wr_en && (rt == write_reg)) begin
            ReadData2 = WriteData;
        end
        if (wr_en && (DbgAddr == write_reg)) begin
            DbgData = WriteData;
        end
`else
`endif
    end

    assign WrCount = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, both write paths, register 0,
// same-cycle hazard, asynchronous reset and counter saturation (second instance, CNT_W=2).
module tb_reg_file;

    logic        CLK = 1'b0;
    logic        clk_en = 1'b0;
    logic        RST_n;
    logic [4:0]  rs, rt, rd, DbgAddr;
    logic        RegDst, RegWre, DBDataSrc;
    logic [31:0] result, DataOut;
    logic [31:0] ReadData1, ReadData2, DbgData, WriteData;
    logic [15:0] WrCount;
    logic [31:0] s_rd1, s_rd2, s_dbg, s_wd;
    logic [1:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = clk_en ? ~CLK : CLK;

    reg_file dut (
        .CLK(CLK), .RST_n(RST_n), .rs(rs), .rt(rt), .rd(rd),
        .RegDst(RegDst), .RegWre(RegWre), .DBDataSrc(DBDataSrc),
        .result(result), .DataOut(DataOut), .DbgAddr(DbgAddr),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .DbgData(DbgData),
        .WriteData(WriteData), .WrCount(WrCount)
    );

    reg_file #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RST_n(RST_n), .rs(rs), .rt(rt), .rd(rd),
        .RegDst(RegDst), .RegWre(RegWre), .DBDataSrc(DBDataSrc),
        .result(result), .DataOut(DataOut), .DbgAddr(DbgAddr),
        .ReadData1(s_rd1), .ReadData2(s_rd2), .DbgData(s_dbg),
        .WriteData(s_wd), .WrCount(s_cnt)
    );

    // Inputs change on the falling edge; RegWre drops 1 ns after the rising edge.
    task automatic do_write(input logic dst, input logic [4:0] t_a, input logic [4:0] d_a,
                            input logic src, input logic [31:0] res, input logic [31:0] dout);
        @(negedge CLK);
        RegDst = dst; rt = t_a; rd = d_a; DBDataSrc = src;
        result = res; DataOut = dout; RegWre = 1'b1;
        @(posedge CLK);
        #1;
        RegWre = 1'b0;
    endtask

    task automatic test_reset;
        RST_n = 1'b1; RegWre = 1'b0; RegDst = 1'b0; DBDataSrc = 1'b0;
        rs = '0; rt = '0; rd = '0; DbgAddr = '0; result = '0; DataOut = '0;
        #1 RST_n = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs = 5'(a); rt = 5'(a); DbgAddr = 5'(a);
            #1;
            checks++;
            if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0 || DbgData !== 32'h0) begin
                errors++;
                $display("FAIL reset_read a=%0d: got %h/%h/%h expected 0", a, ReadData1, ReadData2, DbgData);
            end
        end
        checks++;
        if (WrCount !== 16'd0) begin
            errors++; $display("FAIL reset_wrcount: got %0d expected 0", WrCount);
        end
        checks++;
        if (s_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_wrcount_sat: got %0d expected 0", s_cnt);
        end
        clk_en = 1'b1;
        @(negedge CLK);
        RST_n = 1'b1;
    endtask

    task automatic test_rd_write;
        do_write(1'b1, 5'd0, 5'd5, 1'b0, 32'h0000_00AB, 32'h1111_1111);
        rs = 5'd5;
        #1;
        checks++;
        if (ReadData1 !== 32'h0000_00AB) begin
            errors++; $display("FAIL rd_write_read: got %h expected 000000ab", ReadData1);
        end
        checks++;
        if (s_rd1 !== 32'h0000_00AB) begin
            errors++; $display("FAIL rd_write_read_sat: got %h expected 000000ab", s_rd1);
        end
        checks++;
        if (WrCount !== 16'd1) begin
            errors++; $display("FAIL rd_write_count: got %0d expected 1", WrCount);
        end
    endtask

    task automatic test_rt_write;
        @(negedge CLK);
        RegDst = 1'b0; rt = 5'd7; rd = 5'd9; DBDataSrc = 1'b1;
        result = 32'h2222_2222; DataOut = 32'hDEAD_BEEF; RegWre = 1'b1;
        #1;
        checks++;
        if (WriteData !== 32'hDEAD_BEEF || s_wd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rt_write_wdata: got %h/%h expected deadbeef", WriteData, s_wd);
        end
        @(posedge CLK);
        #1;
        RegWre = 1'b0; DbgAddr = 5'd7;
        #1;
        checks++;
        if (ReadData2 !== 32'hDEAD_BEEF || s_rd2 !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rt_write_rd2: got %h/%h expected deadbeef", ReadData2, s_rd2);
        end
        checks++;
        if (DbgData !== 32'hDEAD_BEEF || s_dbg !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rt_write_dbg: got %h/%h expected deadbeef", DbgData, s_dbg);
        end
        checks++;
        if (WrCount !== 16'd2) begin
            errors++; $display("FAIL rt_write_count: got %0d expected 2", WrCount);
        end
        checks++;
        if (ReadData1 !== 32'h0000_00AB) begin
            errors++; $display("FAIL rt_write_other_reg: got %h expected 000000ab", ReadData1);
        end
    endtask

    task automatic test_reg0;
        @(negedge CLK);
        RegDst = 1'b1; rd = 5'd0; DBDataSrc = 1'b0; result = 32'hFFFF_FFFF;
        rs = 5'd0; DbgAddr = 5'd0; RegWre = 1'b1;
        #1;
        checks++;
        if (ReadData1 !== 32'h0 || DbgData !== 32'h0) begin
            errors++; $display("FAIL reg0_same_cycle: got %h/%h expected 0", ReadData1, DbgData);
        end
        @(posedge CLK);
        #1;
        RegWre = 1'b0;
        #1;
        checks++;
        if (ReadData1 !== 32'h0 || DbgData !== 32'h0) begin
            errors++; $display("FAIL reg0_after_write: got %h/%h expected 0", ReadData1, DbgData);
        end
        checks++;
        if (WrCount !== 16'd2) begin
            errors++; $display("FAIL reg0_count: got %0d expected 2", WrCount);
        end
        @(negedge CLK);
        RegDst = 1'b1; rd = 5'd5; result = 32'h0000_0123; RegWre = 1'b0; rs = 5'd5;
        @(posedge CLK);
        #1;
        checks++;
        if (ReadData1 !== 32'h0000_00AB) begin
            errors++; $display("FAIL no_wre_data: got %h expected 000000ab", ReadData1);
        end
        checks++;
        if (WrCount !== 16'd2) begin
            errors++; $display("FAIL no_wre_count: got %0d expected 2", WrCount);
        end
    endtask

    task automatic test_hazard;
        logic [31:0] exp_pre;
`ifdef RF_BYPASS_EN
        exp_pre = 32'd2;
`else
        exp_pre = 32'd1;
`endif
        do_write(1'b1, 5'd0, 5'd3, 1'b0, 32'd1, 32'd0);
        @(negedge CLK);
        RegDst = 1'b1; rd = 5'd3; DBDataSrc = 1'b0; result = 32'd2; rs = 5'd3; RegWre = 1'b1;
        #1;
        checks++;
        if (ReadData1 !== exp_pre) begin
            errors++; $display("FAIL hazard_before_edge: got %h expected %h", ReadData1, exp_pre);
        end
        @(posedge CLK);
        #1;
        RegWre = 1'b0;
        #1;
        checks++;
        if (ReadData1 !== 32'd2) begin
            errors++; $display("FAIL hazard_after_edge: got %h expected 00000002", ReadData1);
        end
        checks++;
        if (WrCount !== 16'd4) begin
            errors++; $display("FAIL hazard_count: got %0d expected 4", WrCount);
        end
        checks++;
        if (s_cnt !== 2'd3) begin
            errors++; $display("FAIL hazard_count_sat: got %0d expected 3", s_cnt);
        end
    endtask

    task automatic test_async_reset;
        @(posedge CLK);
        #3;
        RST_n = 1'b0; rs = 5'd5; rt = 5'd7; DbgAddr = 5'd3;
        #1;
        checks++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0 || DbgData !== 32'h0) begin
            errors++; $display("FAIL async_reset_reads: got %h/%h/%h expected 0", ReadData1, ReadData2, DbgData);
        end
        checks++;
        if (WrCount !== 16'd0 || s_cnt !== 2'd0) begin
            errors++; $display("FAIL async_reset_count: got %0d/%0d expected 0", WrCount, s_cnt);
        end
        do_write(1'b1, 5'd0, 5'd9, 1'b0, 32'h0000_0055, 32'h0);
        DbgAddr = 5'd9;
        #1;
        checks++;
        if (DbgData !== 32'h0 || WrCount !== 16'd0) begin
            errors++; $display("FAIL write_in_reset: got %h cnt %0d expected 0 cnt 0", DbgData, WrCount);
        end
        @(negedge CLK);
        RST_n = 1'b1;
        do_write(1'b1, 5'd0, 5'd9, 1'b0, 32'h0000_0055, 32'h0);
        #1;
        checks++;
        if (DbgData !== 32'h0000_0055 || WrCount !== 16'd1) begin
            errors++; $display("FAIL first_after_reset: got %h cnt %0d expected 55 cnt 1", DbgData, WrCount);
        end
        for (int i = 0; i < 4; i++) begin
            do_write(1'b0, 5'(10 + i), 5'd0, 1'b1, 32'h0, 32'h100 + 32'(i));
            if (i == 1) begin
                checks++;
                if (s_cnt !== 2'd3) begin
                    errors++; $display("FAIL sat_reach: got %0d expected 3", s_cnt);
                end
            end
        end
        rt = 5'd13;
        #1;
        checks++;
        if (s_cnt !== 2'd3) begin
            errors++; $display("FAIL sat_hold: got %0d expected 3", s_cnt);
        end
        checks++;
        if (WrCount !== 16'd5) begin
            errors++; $display("FAIL count_five: got %0d expected 5", WrCount);
        end
        checks++;
        if (ReadData2 !== 32'h0000_0103) begin
            errors++; $display("FAIL back_to_back_last: got %h expected 00000103", ReadData2);
        end
    endtask

    initial begin
        test_reset();
        test_rd_write();
        test_rt_write();
        test_reg0();
        test_hazard();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1);
    end

endmodule
